mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM (1-cycle read latency) between three requesters.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for CPU fetch (IF), load/store (D) and debug (DBG) requesters.
// Optional `ARB_RR_EN selects round-robin IF/D base policy; default is fixed D > IF.
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner_dbg
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_IF   = 2'd0,
    OWN_D    = 2'd1,
    OWN_DBG  = 2'd2,
    OWN_NONE = 2'd3
  } owner_t;

  logic [CW-1:0] r_if_cnt;
  logic [CW-1:0] r_d_cnt;
  owner_t        r_owner;
  logic          r_if_rv;
  logic          r_d_rv;
  logic          r_dbg_rv;
`ifdef ARB_RR_EN
  owner_t        r_rr_ptr;
`endif

  owner_t        w_sel;
  logic          w_if_starved;
  logic          w_d_starved;

  function automatic logic [CW-1:0] cnt_next(input logic          req,
                                             input logic          gnt,
                                             input logic [CW-1:0] cnt);
    if (!req || gnt)       return '0;
    else if (cnt == CNT_MAX) return CNT_MAX;
    else                   return cnt + 1'b1;
  endfunction

  // Grant selection; reset suppresses all grants so nothing reaches the RAM while held.
  always_comb begin
    w_if_starved = if_req && (r_if_cnt == CNT_MAX);
    w_d_starved  = d_req  && (r_d_cnt  == CNT_MAX);
    w_sel        = OWN_NONE;
    if (reset)             w_sel = OWN_NONE;
    else if (dbg_req)      w_sel = OWN_DBG;
    else if (dbg_lock)     w_sel = OWN_NONE;
    else if (w_if_starved) w_sel = OWN_IF;
    else if (w_d_starved)  w_sel = OWN_D;
    else if (if_req && d_req) begin
`ifdef ARB_RR_EN
      w_sel = r_rr_ptr;
`else
      w_sel = OWN_D;
`endif
    end
    else if (if_req)       w_sel = OWN_IF;
    else if (d_req)        w_sel = OWN_D;
  end

  assign if_gnt  = (w_sel == OWN_IF);
  assign d_gnt   = (w_sel == OWN_D);
  assign dbg_gnt = (w_sel == OWN_DBG);

  always_comb begin
    mem_en    = (w_sel != OWN_NONE);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_sel)
      OWN_IF: begin
        mem_addr = if_addr;
      end
      OWN_D: begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      OWN_DBG: begin
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  // Returning reads are dropped while reset is high, so an in-flight read never completes.
  assign if_rvalid  = r_if_rv  & ~reset;
  assign d_rvalid   = r_d_rv   & ~reset;
  assign dbg_rvalid = r_dbg_rv & ~reset;
  assign owner_dbg  = reset ? OWN_NONE : r_owner;
  assign rdata      = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_cnt <= '0;
      r_d_cnt  <= '0;
      r_owner  <= OWN_NONE;
      r_if_rv  <= 1'b0;
      r_d_rv   <= 1'b0;
      r_dbg_rv <= 1'b0;
`ifdef ARB_RR_EN
      r_rr_ptr <= OWN_D;
`endif
    end else begin
      r_if_cnt <= cnt_next(if_req, if_gnt, r_if_cnt);
      r_d_cnt  <= cnt_next(d_req, d_gnt, r_d_cnt);
      r_owner  <= w_sel;
      r_if_rv  <= if_gnt;
      r_d_rv   <= d_gnt & ~d_we;
      r_dbg_rv <= dbg_gnt & ~dbg_we;
`ifdef ARB_RR_EN
      if (if_gnt)     r_rr_ptr <= OWN_D;
      else if (d_gnt) r_rr_ptr <= OWN_IF;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a priority-list reference model and a shadow RAM.
module tb_mem_port_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int MAXW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    owner_dbg;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner_dbg(owner_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i * 257) ^ 16'h5A5A;
  endfunction

  // Bench RAM driven by the DUT's memory port.
  logic [DW-1:0] ram [256];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model: owner codes 0=IF 1=D 2=DBG 3=none.
  int m_if_cnt = 0, m_d_cnt = 0, m_ptr = 1, m_prev = 3, m_pend = 3, m_g = 3;
  logic [DW-1:0] m_pdata = '0;
  logic [DW-1:0] ref_mem [256];
  bit mdl_ready = 1'b0;

  function automatic int mdl_pick();
    if (reset)                     return 3;
    if (dbg_req)                   return 2;
    if (dbg_lock)                  return 3;
    if (if_req && m_if_cnt == MAXW) return 0;
    if (d_req && m_d_cnt == MAXW)   return 1;
    if (if_req && d_req) begin
`ifdef ARB_RR_EN
      return m_ptr;
`else
      return 1;
`endif
    end
    if (if_req) return 0;
    if (d_req)  return 1;
    return 3;
  endfunction

  function automatic bit exp_we();
    case (mdl_pick())
      1: return d_we;
      2: return dbg_we;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [AW-1:0] exp_addr();
    case (mdl_pick())
      0: return if_addr;
      1: return d_addr;
      2: return dbg_addr;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_wdata();
    return (mdl_pick() == 1) ? d_wdata : dbg_wdata;
  endfunction

  function automatic int sat_inc(input int c);
    return (c + 1 > MAXW) ? MAXW : c + 1;
  endfunction

  always @(posedge clk) begin
    if (!mdl_ready) begin
      for (int i = 0; i < 256; i++) ref_mem[i] <= pat(i);
      mdl_ready <= 1'b1;
    end
    if (reset) begin
      m_if_cnt <= 0; m_d_cnt <= 0; m_ptr <= 1; m_prev <= 3; m_pend <= 3;
    end else begin
      m_prev <= m_g;
      m_pend <= 3;
      case (m_g)
        0: begin m_pend <= 0; m_pdata <= ref_mem[if_addr]; end
        1: if (d_we) ref_mem[d_addr] <= d_wdata;
           else begin m_pend <= 1; m_pdata <= ref_mem[d_addr]; end
        2: if (dbg_we) ref_mem[dbg_addr] <= dbg_wdata;
           else begin m_pend <= 2; m_pdata <= ref_mem[dbg_addr]; end
        default: ;
      endcase
      m_if_cnt <= (if_req && m_g != 0) ? sat_inc(m_if_cnt) : 0;
      m_d_cnt  <= (d_req  && m_g != 1) ? sat_inc(m_d_cnt)  : 0;
      if (m_g == 0)      m_ptr <= 1;
      else if (m_g == 1) m_ptr <= 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, half a cycle away from the active edge.
  always @(negedge clk) begin
    check("if_gnt",  32'(if_gnt),  32'(mdl_pick() == 0));
    check("d_gnt",   32'(d_gnt),   32'(mdl_pick() == 1));
    check("dbg_gnt", 32'(dbg_gnt), 32'(mdl_pick() == 2));
    check("mem_en",  32'(mem_en),  32'(mdl_pick() != 3));
    check("mem_we",  32'(mem_we),  32'(exp_we()));
    if (mdl_pick() != 3) check("mem_addr", 32'(mem_addr), 32'(exp_addr()));
    if (exp_we())        check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata()));
    check("if_rvalid",  32'(if_rvalid),  32'(!reset && m_pend == 0));
    check("d_rvalid",   32'(d_rvalid),   32'(!reset && m_pend == 1));
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(!reset && m_pend == 2));
    if (!reset && m_pend != 3) check("rdata", 32'(rdata), 32'(m_pdata));
    check("owner_dbg", 32'(owner_dbg), reset ? 32'd3 : 32'(m_prev));
    m_g <= mdl_pick();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; d_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    d_we = 1'b0; dbg_we = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int lit;
    int g;
    #1;
    repeat (2) cyc();
    reset = 1'b0;

    // 1: lone IF stream over addresses 0..4
    if_req = 1'b1; if_addr = 8'h00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t1_if_gnt", 32'(if_gnt), 32'd1);
      if (k > 0) begin
        check("t1_if_rvalid", 32'(if_rvalid), 32'd1);
        check("t1_rdata", 32'(rdata), 32'(pat(k - 1)));
      end
      cyc();
      if_addr = AW'(k + 1);
      if (k == 4) if_req = 1'b0;
    end
    @(negedge clk);
    check("t1_if_rvalid_last", 32'(if_rvalid), 32'd1);
    check("t1_rdata_last", 32'(rdata), 32'(pat(4)));
    cyc();

    // 2: debug write beats pending IF and D
    if_req = 1'b1; if_addr = 8'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h10; dbg_wdata = 16'hBEEF;
    @(negedge clk);
    check("t2_dbg_gnt", 32'(dbg_gnt), 32'd1);
    check("t2_if_gnt", 32'(if_gnt), 32'd0);
    check("t2_d_gnt", 32'(d_gnt), 32'd0);
    check("t2_mem_we", 32'(mem_we), 32'd1);
    check("t2_mem_addr", 32'(mem_addr), 32'h10);
    cyc();
    idle();
    @(negedge clk);
    check("t2_no_rvalid", 32'(dbg_rvalid | d_rvalid | if_rvalid), 32'd0);
    cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    @(negedge clk);
    check("t2_d_gnt_rd", 32'(d_gnt), 32'd1);
    cyc();
    d_req = 1'b0;
    @(negedge clk);
    check("t2_d_rvalid", 32'(d_rvalid), 32'd1);
    check("t2_rdata", 32'(rdata), 32'hBEEF);
    cyc();

    // 3/4: IF and D held continuously from reset
    do_reset();
    if_req = 1'b1; if_addr = 8'h01;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
    for (int c = 0; c < 12; c++) begin
`ifdef ARB_RR_EN
      lit = (c % 2 == 0) ? 1 : 0;
`else
      lit = (c == 7) ? 0 : 1;
`endif
      @(negedge clk);
      check("t3_d_gnt", 32'(d_gnt), 32'(lit == 1));
      check("t3_if_gnt", 32'(if_gnt), 32'(lit == 0));
      check("t3_model", 32'(mdl_pick()), 32'(lit));
      cyc();
    end

    // 5: debug lock starves IF until released
    do_reset();
    dbg_lock = 1'b1; if_req = 1'b1; if_addr = 8'h03;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t5_if_gnt_locked", 32'(if_gnt), 32'd0);
      cyc();
    end
    check("t5_model_cnt", 32'(m_if_cnt), 32'd7);
    dbg_lock = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h04;
    @(negedge clk);
    check("t5_if_gnt_release", 32'(if_gnt), 32'd1);
    check("t5_d_gnt_release", 32'(d_gnt), 32'd0);
    cyc();

    // 6: reset right after a D read grant
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05;
    @(negedge clk);
    check("t6_d_gnt", 32'(d_gnt), 32'd1);
    cyc();
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("t6_d_rvalid_rst", 32'(d_rvalid), 32'd0);
    check("t6_owner_rst", 32'(owner_dbg), 32'd3);
    check("t6_mem_en_rst", 32'(mem_en), 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("t6_d_rvalid_after", 32'(d_rvalid), 32'd0);
    check("t6_owner_after", 32'(owner_dbg), 32'd3);
    cyc();

    // Randomized traffic honouring the hold-until-grant contract
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      g = mdl_pick();
      cyc();
      reset = ($urandom_range(0, 299) == 0);
      if (!if_req || g == 0) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = AW'($urandom_range(0, 15));
      end else if ($urandom_range(0, 7) == 0) if_req = 1'b0;
      if (!d_req || g == 1) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = AW'($urandom_range(0, 15));
        d_wdata = DW'($urandom);
      end else if ($urandom_range(0, 7) == 0) d_req = 1'b0;
      if (!dbg_req || g == 2) begin
        dbg_req   = ($urandom_range(0, 5) == 0);
        dbg_we    = $urandom_range(0, 1) == 1;
        dbg_addr  = AW'($urandom_range(0, 15));
        dbg_wdata = DW'($urandom);
      end else if ($urandom_range(0, 7) == 0) dbg_req = 1'b0;
      if (dbg_lock) dbg_lock = ($urandom_range(0, 5) != 0);
      else          dbg_lock = ($urandom_range(0, 49) == 0);
    end

    idle();
    reset = 1'b0;
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
